// File: rtl/multicycle_sequencer.sv
// Multi-cycle RV32I sequencer: walks FETCH/DECODE/EXECUTE/MEM/WB, issues datapath
// strobes, and owns the memory request/ready handshake with its timeout.
module multicycle_sequencer #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8   // 2**CNT_W must exceed TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic        aluEq,
  input  logic        memReady,
  output logic        memReq,
  output logic        memWe,
  output logic        memAddrSel,
  output logic        irWrite,
  output logic        regWrite,
  output logic        pcWrite,
  output logic        pcSrc,
  output logic [2:0]  state,
  output logic [31:0] instret,
  output logic        illegal,
  output logic        busErr
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    C_ALU, C_LOAD, C_STORE, C_BEQ, C_BNE
  } cls_t;

  state_t           st;
  cls_t             cls;
  cls_t             dec_cls;
  logic             dec_ok;
  logic [CNT_W-1:0] wait_cnt;
  logic             mem_phase;
  logic             timeout_hit;
  logic             retire;
  logic             unused_inst;

  assign unused_inst = ^{inst[31:15], inst[11:7]};

  always_comb begin
    dec_ok  = 1'b1;
    dec_cls = C_ALU;
    case (inst[6:0])
      7'b0110011, 7'b0010011: dec_cls = C_ALU;
      7'b0000011:             dec_cls = C_LOAD;
      7'b0100011:             dec_cls = C_STORE;
      7'b1100011: begin
        if (inst[14:12] == 3'b000)      dec_cls = C_BEQ;
        else if (inst[14:12] == 3'b001) dec_cls = C_BNE;
        else                            dec_ok  = 1'b0;
      end
      default: dec_ok = 1'b0;
    endcase
  end

  assign mem_phase   = (st == S_FETCH) || (st == S_MEM);
  // memReady in the timeout cycle takes priority over the timeout
  assign timeout_hit = mem_phase && !memReady && (wait_cnt == CNT_W'(TIMEOUT));

  assign retire = ((st == S_EXEC) && ((cls == C_BEQ) || (cls == C_BNE)))
               || ((st == S_MEM) && (cls == C_STORE) && memReady)
               || (st == S_WB);

  // Async reset parks state in FETCH, so request/Mealy strobes are gated by rst too
  assign memReq     = mem_phase && !rst;
  assign memAddrSel = (st == S_MEM);
  assign memWe      = (st == S_MEM) && (cls == C_STORE);
  assign irWrite    = (st == S_FETCH) && memReady && !rst;
  assign regWrite   = (st == S_WB);
  assign pcWrite    = retire;
  assign pcSrc      = (st == S_EXEC) &&
                      (((cls == C_BEQ) && aluEq) || ((cls == C_BNE) && !aluEq));
  assign state      = st;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= S_FETCH;
      cls      <= C_ALU;
      wait_cnt <= '0;
      instret  <= '0;
      illegal  <= 1'b0;
      busErr   <= 1'b0;
    end else begin
      if (retire) instret <= instret + 32'd1;

      if (!mem_phase || memReady || timeout_hit) wait_cnt <= '0;
      else                                       wait_cnt <= wait_cnt + 1'b1;

      case (st)
        S_FETCH: begin
          if (memReady) st <= S_DECODE;
          else if (timeout_hit) begin
            st     <= S_TRAP;
            busErr <= 1'b1;
          end
        end
        S_DECODE: begin
          if (dec_ok) begin
            cls <= dec_cls;
            st  <= S_EXEC;
          end else begin
            illegal <= 1'b1;
            st      <= S_TRAP;
          end
        end
        S_EXEC: begin
          case (cls)
            C_ALU:           st <= S_WB;
            C_LOAD, C_STORE: st <= S_MEM;
            default:         st <= S_FETCH;
          endcase
        end
        S_MEM: begin
          if (memReady) st <= (cls == C_LOAD) ? S_WB : S_FETCH;
          else if (timeout_hit) begin
            st     <= S_TRAP;
            busErr <= 1'b1;
          end
        end
        S_WB:    st <= S_FETCH;
        S_TRAP:  st <= S_TRAP;
        default: st <= S_TRAP;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: walks ALU/load/store/branch flows, illegal
// trap, fetch timeout and its boundary, and an async reset during a store's MEM wait.
module tb_multicycle_sequencer;

  localparam logic [31:0] I_ADD = 32'h003100B3;
  localparam logic [31:0] I_LW  = 32'h0002A303;
  localparam logic [31:0] I_SW  = 32'h0062A023;
  localparam logic [31:0] I_BEQ = 32'h00208463;
  localparam logic [31:0] I_BNE = 32'h00209463;
  localparam logic [31:0] I_ILL = 32'h0000007F;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst;
  logic        aluEq;
  logic        memReady;
  logic        memReq, memWe, memAddrSel, irWrite, regWrite, pcWrite, pcSrc;
  logic [2:0]  state;
  logic [31:0] instret;
  logic        illegal, busErr;

  int checks   = 0;
  int failures = 0;

  multicycle_sequencer #(.TIMEOUT(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .inst(inst), .aluEq(aluEq), .memReady(memReady),
    .memReq(memReq), .memWe(memWe), .memAddrSel(memAddrSel), .irWrite(irWrite),
    .regWrite(regWrite), .pcWrite(pcWrite), .pcSrc(pcSrc), .state(state),
    .instret(instret), .illegal(illegal), .busErr(busErr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // advance one cycle and sample well away from the edge
  task automatic nxt;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset;
    rst = 1'b1; memReady = 1'b1; aluEq = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state",   {29'd0, state}, 0);
    chk("rst_memReq",  {31'd0, memReq}, 0);
    chk("rst_irWrite", {31'd0, irWrite}, 0);
    chk("rst_pcWrite", {31'd0, pcWrite}, 0);
    chk("rst_instret", instret, 0);
    chk("rst_flags",   {30'd0, illegal, busErr}, 0);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    inst = I_ADD; aluEq = 1'b0; memReady = 1'b1; rst = 1'b1;
    do_reset();

    // ADD, zero wait: 0->1->2->4->0
    inst = I_ADD; memReady = 1'b1; #1;
    chk("add_c0_state",  {29'd0, state}, 0);
    chk("add_c0_ir",     {31'd0, irWrite}, 1);
    chk("add_c0_req",    {30'd0, memReq, memAddrSel}, 32'b10);
    nxt; chk("add_c1_state", {29'd0, state}, 1);
    chk("add_c1_req_ir", {30'd0, memReq, irWrite}, 0);
    nxt; chk("add_c2_state", {29'd0, state}, 2);
    chk("add_c2_pcw",    {31'd0, pcWrite}, 0);
    nxt; chk("add_c3_state", {29'd0, state}, 4);
    chk("add_c3_strobes", {29'd0, regWrite, pcWrite, pcSrc}, 32'b110);
    chk("add_c3_instret", instret, 0);
    nxt; chk("add_c4_state", {29'd0, state}, 0);
    chk("add_instret",   instret, 1);

    // LW with two wait states in MEM
    inst = I_LW; #1;
    chk("lw_c0_ir", {31'd0, irWrite}, 1);
    nxt; chk("lw_c1_state", {29'd0, state}, 1);
    nxt; chk("lw_c2_state", {29'd0, state}, 2);
    nxt; memReady = 1'b0; #1;
    chk("lw_m0", {27'd0, state, memReq, memWe, memAddrSel}, {27'd0, 3'd3, 3'b101});
    nxt;
    chk("lw_m1", {27'd0, state, memReq, memWe, memAddrSel}, {27'd0, 3'd3, 3'b101});
    memReady = 1'b1; #1;
    chk("lw_m2", {27'd0, state, memReq, memWe, memAddrSel}, {27'd0, 3'd3, 3'b101});
    chk("lw_m2_pcw", {30'd0, pcWrite, regWrite}, 0);
    nxt; chk("lw_wb", {29'd0, regWrite, pcWrite, pcSrc}, 32'b110);
    chk("lw_wb_state", {29'd0, state}, 4);
    nxt; chk("lw_done_state", {29'd0, state}, 0);
    chk("lw_instret", instret, 2);

    // SW zero wait: retires in MEM
    inst = I_SW; #1;
    nxt; nxt;
    nxt; chk("sw_mem_state", {29'd0, state}, 3);
    chk("sw_mem_strobes", {27'd0, memReq, memWe, pcWrite, pcSrc, regWrite}, 32'b11100);
    nxt; chk("sw_done_state", {29'd0, state}, 0);
    chk("sw_instret", instret, 3);

    // BEQ taken
    inst = I_BEQ; aluEq = 1'b1; #1;
    nxt; nxt;
    chk("beq_exec_state", {29'd0, state}, 2);
    chk("beq_exec", {28'd0, pcWrite, pcSrc, regWrite, memReq}, 32'b1100);
    nxt; chk("beq_done_state", {29'd0, state}, 0);
    chk("beq_instret", instret, 4);

    // BNE with equal operands: not taken
    inst = I_BNE; aluEq = 1'b1; #1;
    nxt; nxt;
    chk("bne_exec", {29'd0, pcWrite, pcSrc, regWrite}, 32'b100);
    nxt; chk("bne_done_state", {29'd0, state}, 0);
    chk("bne_instret", instret, 5);

    // Illegal opcode traps from DECODE
    inst = I_ILL; aluEq = 1'b0; #1;
    nxt; chk("ill_decode", {29'd0, state}, 1);
    nxt; chk("ill_trap", {29'd0, state}, 7);
    chk("ill_flag", {31'd0, illegal}, 1);
    for (int k = 0; k < 20; k++) begin
      nxt; chk("ill_req_low", {31'd0, memReq}, 0);
    end
    chk("ill_state_hold", {29'd0, state}, 7);
    chk("ill_instret", instret, 5);

    // Fetch timeout: 5 request cycles then TRAP
    do_reset();
    inst = I_ADD; memReady = 1'b0; #1;
    for (int k = 0; k < 5; k++) begin
      chk("to_wait", {30'd0, state[1:0], memReq}, 32'b001);
      nxt;
    end
    chk("to_trap", {29'd0, state}, 7);
    chk("to_buserr", {31'd0, busErr}, 1);
    chk("to_req_low", {31'd0, memReq}, 0);
    nxt; chk("to_req_low2", {31'd0, memReq}, 0);

    // memReady on the timeout cycle completes normally
    do_reset();
    memReady = 1'b0; #1;
    for (int k = 0; k < 4; k++) nxt;
    memReady = 1'b1; #1;
    chk("tb_ir", {31'd0, irWrite}, 1);
    nxt; chk("tb_decode", {29'd0, state}, 1);
    chk("tb_buserr", {31'd0, busErr}, 0);
    nxt; nxt; nxt;
    chk("tb_add_instret", instret, 1);

    // Async reset during a store's MEM wait
    inst = I_SW; #1;
    nxt; nxt;
    nxt; memReady = 1'b0; #1;
    chk("rm_mem", {28'd0, state, memReq}, {28'd0, 3'd3, 1'b1});
    nxt;
    memReady = 1'b1; rst = 1'b1; #1;
    chk("rm_req_drop", {31'd0, memReq}, 0);
    chk("rm_pcw",      {30'd0, pcWrite, regWrite}, 0);
    chk("rm_state",    {29'd0, state}, 0);
    chk("rm_instret",  instret, 0);
    @(posedge clk); #1;
    rst = 1'b0; #1;
    chk("rm_resume", {27'd0, state, memReq, memAddrSel}, {27'd0, 3'd0, 2'b10});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
